// File: rtl/led_matrix_driver.sv
// Column-scanned 4x4 LED matrix driver with frame-synchronous double-buffered pattern,
// per-slot blanking against ghosting and frame-counted blink.
module led_matrix_driver #(
  parameter int DWELL        = 1000,
  parameter int BLANK        = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pat_in,
  input  logic        pat_load,
  input  logic        blink_en,
  output logic [3:0]  led_col,
  output logic [3:0]  led_row,
  output logic        frame_start,
  output logic        pat_pending
);

  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
  localparam logic [BW-1:0] BF_LAST  = BW'(BLINK_FRAMES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    slot_q, slot_d;
  logic [BW-1:0] bfc_q, bfc_d;
  logic          phase_q, phase_d;
  logic          seen_q, seen_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pending_q, pending_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    row_q, row_d;
  logic          fs_q, fs_d;

  logic          wrap;
  logic          boundary;
  logic [1:0]    col_idx;
  logic [3:0]    row_sel;

  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    boundary = wrap && (slot_q == 2'd3);
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    slot_d   = wrap ? slot_q + 2'd1 : slot_q;

    bfc_d   = bfc_q;
    phase_d = phase_q;
    seen_d  = seen_q;
    if (boundary) begin
      seen_d = 1'b1;
      if (bfc_q == BF_LAST) begin
        bfc_d   = '0;
        phase_d = ~phase_q;
      end else begin
        bfc_d = bfc_q + 1'b1;
      end
    end

    // A load coinciding with the boundary bypasses the pending buffer entirely.
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (boundary) begin
      if (pat_load) begin
        disp_d    = pat_in;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = pend_q;
        pending_d = 1'b0;
      end
    end else if (pat_load) begin
      pend_d    = pat_in;
      pending_d = 1'b1;
    end

    col_idx = 2'd3 - slot_q;
    for (int r = 0; r < 4; r++) begin
      row_sel[r] = disp_q[4*r + int'(col_idx)];
    end

    col_d = 4'b1111;
    row_d = 4'b0000;
    if (int'(cnt_q) >= BLANK) begin
      col_d = ~(4'b0001 << col_idx);
      row_d = (blink_en && phase_q) ? 4'b0000 : row_sel;
    end
    fs_d = seen_q && (slot_q == 2'd0) && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      slot_q    <= '0;
      bfc_q     <= '0;
      phase_q   <= 1'b0;
      seen_q    <= 1'b0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      col_q     <= 4'b1111;
      row_q     <= 4'b0000;
      fs_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      bfc_q     <= bfc_d;
      phase_q   <= phase_d;
      seen_q    <= seen_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      col_q     <= col_d;
      row_q     <= row_d;
      fs_q      <= fs_d;
    end
  end

  assign led_col     = col_q;
  assign led_row     = row_q;
  assign frame_start = fs_q;
  assign pat_pending = pending_q;

endmodule

// File: tb/tb_led_matrix_driver.sv
// Bench for led_matrix_driver (DWELL=8, BLANK=2, BLINK_FRAMES=2): per-cycle expected outputs
// from a position-based model go through a queue; scenario tasks add explicit pattern checks.
module tb_led_matrix_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pat_in;
  logic        pat_load;
  logic        blink_en;
  logic [3:0]  led_col;
  logic [3:0]  led_row;
  logic        frame_start;
  logic        pat_pending;

  int errors = 0;
  int checks = 0;

  // Model: p = scan position (cycles since reset release) that the next edge's outputs show.
  int          p = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_pend = '0;
  logic        m_pending = 1'b0;
  logic [9:0]  expq[$];
  logic [9:0]  e, obs;

  led_matrix_driver #(.DWELL(8), .BLANK(2), .BLINK_FRAMES(2)) dut (
    .clk(clk), .rst(rst), .pat_in(pat_in), .pat_load(pat_load), .blink_en(blink_en),
    .led_col(led_col), .led_row(led_row), .frame_start(frame_start), .pat_pending(pat_pending)
  );

  always #5 clk = ~clk;

  task automatic drive_cycle(input logic ld, input logic [15:0] d);
    logic [3:0] col, row;
    logic       fs;
    int         dw, sl, c;
    pat_load = ld;
    pat_in   = d;
    if (!rst) begin
      p = 0; m_disp = '0; m_pend = '0; m_pending = 1'b0;
      expq.push_back({4'b1111, 4'b0000, 1'b0, 1'b0});
    end else begin
      dw = p % 8;
      sl = (p / 8) % 4;
      col = 4'b1111;
      row = 4'b0000;
      if (dw >= 2) begin
        col = ~(4'b1000 >> sl);
        c = 3 - sl;
        for (int r = 0; r < 4; r++) row[r] = m_disp[r*4 + c];
        if (blink_en && (((p / 32) / 2) % 2 == 1)) row = 4'b0000;
      end
      fs = (p > 0) && (p % 32 == 0);
      if (p % 32 == 31) begin
        if (ld) begin m_disp = d; m_pending = 1'b0; end
        else if (m_pending) begin m_disp = m_pend; m_pending = 1'b0; end
      end else if (ld) begin
        m_pend = d; m_pending = 1'b1;
      end
      p++;
      expq.push_back({col, row, fs, m_pending});
    end
    @(posedge clk);
    #1;
    pat_load = 1'b0;
  endtask

  function automatic logic [3:0] diag_row(input logic [3:0] col);
    case (col)
      4'b0111: return 4'b1000;
      4'b1011: return 4'b0100;
      4'b1101: return 4'b0010;
      4'b1110: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 16'h0);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL reset cyc%0d: got %b want %b", i, obs, e); end
    end
  endtask

  task automatic test_scan();
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b0, 16'h0);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL scan cyc%0d: got %b want %b", i, obs, e); end
      if (i == 2 || i == 32) begin
        checks++;
        if ({led_col, frame_start} !== ((i == 2) ? 5'b0111_0 : 5'b1111_1)) begin
          errors++; $display("FAIL scan_edge cyc%0d: col=%b fs=%b", i, led_col, frame_start);
        end
      end
    end
  endtask

  task automatic test_diagonal();
    while (p % 32 != 0) begin
      drive_cycle(1'b0, 16'h0);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL diag_align: got %b want %b", obs, e); end
    end
    for (int i = 0; i < 64; i++) begin
      drive_cycle(i == 5, 16'h8421);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL diag cyc%0d: got %b want %b", i, obs, e); end
      if (i >= 5 && i <= 30) begin
        checks++;
        if ({pat_pending, led_row} !== 5'b1_0000) begin
          errors++; $display("FAIL diag_pending cyc%0d: pend=%b row=%b want 1/0000", i, pat_pending, led_row);
        end
      end
      if (i >= 32) begin
        checks++;
        if ({pat_pending, led_row} !== {1'b0, diag_row(led_col)}) begin
          errors++; $display("FAIL diag_rows cyc%0d: col=%b row=%b want %b", i, led_col, led_row, diag_row(led_col));
        end
      end
    end
  endtask

  task automatic test_last_wins();
    while (p % 32 != 0) begin
      drive_cycle(1'b0, 16'h0);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL lastwins_align: got %b want %b", obs, e); end
    end
    for (int i = 0; i < 64; i++) begin
      drive_cycle(i == 3 || i == 10, (i == 3) ? 16'h000F : 16'hF000);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL lastwins cyc%0d: got %b want %b", i, obs, e); end
      if (i >= 32) begin
        checks++;
        if (led_row !== ((led_col == 4'b1111) ? 4'b0000 : 4'b1000)) begin
          errors++; $display("FAIL lastwins_rows cyc%0d: col=%b row=%b", i, led_col, led_row);
        end
      end
    end
  endtask

  task automatic test_boundary_load();
    while (p % 32 != 0) begin
      drive_cycle(1'b0, 16'h0);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL bnd_align: got %b want %b", obs, e); end
    end
    for (int i = 0; i < 64; i++) begin
      drive_cycle(i == 31, 16'hFFFF);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL bnd cyc%0d: got %b want %b", i, obs, e); end
      checks++;
      if (pat_pending !== 1'b0) begin
        errors++; $display("FAIL bnd_pending cyc%0d: got %b want 0", i, pat_pending);
      end
      if (i >= 32 && led_row !== ((led_col == 4'b1111) ? 4'b0000 : 4'b1111)) begin
        errors++; $display("FAIL bnd_rows cyc%0d: col=%b row=%b", i, led_col, led_row);
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] want;
    rst = 1'b0;
    drive_cycle(1'b0, 16'h0);
    e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
    if (obs !== e) begin errors++; $display("FAIL blink_reset: got %b want %b", obs, e); end
    rst = 1'b1;
    blink_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      if (i == 192) blink_en = 1'b0;
      drive_cycle(i == 31, 16'hFFFF);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL blink cyc%0d: got %b want %b", i, obs, e); end
      if (i % 8 >= 2) begin
        if (i < 32) want = 4'b0000;
        else if (i < 192 && ((i / 32) / 2) % 2 == 1) want = 4'b0000;
        else want = 4'b1111;
        checks++;
        if (led_row !== want || led_col !== ~(4'b1000 >> ((i / 8) % 4))) begin
          errors++; $display("FAIL blink_rows cyc%0d: col=%b row=%b want row %b", i, led_col, led_row, want);
        end
      end
    end
  endtask

  task automatic test_midreset();
    while (p % 32 != 12) begin
      drive_cycle(1'b0, 16'h0);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL midrst_run: got %b want %b", obs, e); end
    end
    rst = 1'b0;
    drive_cycle(1'b0, 16'h0);
    e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
    if (obs !== e) begin errors++; $display("FAIL midrst_hold: got %b want %b", obs, e); end
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive_cycle(1'b0, 16'h0);
      e = expq.pop_front(); obs = {led_col, led_row, frame_start, pat_pending}; checks++;
      if (obs !== e) begin errors++; $display("FAIL midrst cyc%0d: got %b want %b", i, obs, e); end
      checks++;
      if (led_row !== 4'b0000 || (i == 2 && led_col !== 4'b0111)) begin
        errors++; $display("FAIL midrst_restart cyc%0d: col=%b row=%b", i, led_col, led_row);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    pat_in = '0;
    pat_load = 1'b0;
    blink_en = 1'b0;
    #1;
    test_reset();
    test_scan();
    test_diagonal();
    test_last_wins();
    test_boundary_load();
    test_blink();
    test_midreset();
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL queue_drain: %0d left want 0", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_matrix_driver.md
Name: led_matrix_driver

Overview:
- Output-side counterpart of the 4x4 keypad matrix scanner: takes a 16-bit pattern in the same bit layout as the keypad's mem_val and drives a 4x4 LED matrix by column scanning.
- Columns are driven active-low, one at a time, in the same column order the keypad scanner uses. Rows are driven active-high.
- Pattern updates are double-buffered and take effect only at frame boundaries, so the display never tears.
- Adds inter-column blanking against ghosting and an optional frame-counted blink.

Parameters:
- DWELL, 1000, clock cycles per column slot; legal range >= 2.
- BLANK, 16, cycles at the start of each slot with all columns and rows off; legal range 0 <= BLANK < DWELL.
- BLINK_FRAMES, 64, frames per blink half-period; legal range >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous and active-low (0 = reset).
- pat_in  in  16  pattern; bit r*4+c = LED at row r, column c.
- pat_load  in  1  1-cycle strobe; capture pat_in.
- blink_en  in  1  1 = blink display at BLINK_FRAMES rate.
- led_col  out  4  column drive, active-low, at most one bit low.
- led_row  out  4  row data for the active column, active-high.
- frame_start  out  1  1-cycle pulse at the start of each frame.
- pat_pending  out  1  a loaded pattern is waiting for the frame boundary.

Behaviour:
- Reset (rst=0 at an edge) clears all of the following:
  - dwell_cnt=0, slot=0, blink frame counter=0, blink phase=0 (on).
  - disp=0, pend=0.
  - led_col=4'b1111, led_row=4'b0000, frame_start=0, pat_pending=0.
- Reset mid-frame or mid-column aborts the scan immediately; no pulse is emitted.
- dwell_cnt counts 0..DWELL-1 every clock.
  - When it wraps, slot advances 0..3.
  - When slot wraps 3->0, that edge is the frame boundary.
- Column mapping by slot:
  - slot 0 -> led_col 0111 (column 3).
  - slot 1 -> 1011 (column 2).
  - slot 2 -> 1101 (column 1).
  - slot 3 -> 1110 (column 0).
- Output decode:
  - Active column c: led_row[r] = disp[r*4+c].
  - While dwell_cnt < BLANK: led_col=1111, led_row=0000.
  - Blink: if blink_en=1 and blink phase=1 (off), led_row=0000 but led_col still scans.
- Latency: led_col, led_row and frame_start are registered one cycle behind the counters.
  - After the k-th edge following reset release, outputs reflect the counter state after edge k-1.
  - Example with DWELL=8, BLANK=2: edges 1-2 give blank, edges 3-8 give 0111, edges 9-10 give blank, edges 11-16 give 1011.
- frame_start:
  - High for exactly one cycle: the cycle after the first edge at which the registered outputs show slot 0, dwell 0 following a frame boundary.
  - No pulse for the initial frame after reset.
- Pattern load:
  - pat_load=1 captures pat_in into pend and sets pat_pending=1.
  - Several loads within one frame: the last one wins.
  - At the frame boundary edge: if pat_pending, disp<=pend and pat_pending<=0.
  - pat_load on the boundary edge itself: pat_in goes straight to disp and pat_pending stays 0.
  - disp never changes at any other time.
- Blink:
  - The frame counter increments at every frame boundary.
  - On reaching BLINK_FRAMES it returns to 0 and toggles the phase.
  - The counter runs regardless of blink_en; blink_en only gates led_row.
- led_col is never all-zero and never has more than one zero bit, in any cycle.

Test Plan (DWELL=8, BLANK=2, BLINK_FRAMES=2; frame = 32 cycles):
- Reset and scan:
  - Hold rst=0 for 3 cycles -> led_col=1111, led_row=0000, frame_start=0, pat_pending=0.
  - After release: 2 cycles blank, then 0111 x6, 2 blank, 1011 x6, 2 blank, 1101 x6, 2 blank, 1110 x6, rows 0000 throughout.
  - frame_start pulses 1 cycle at the start of the second frame.
- Diagonal:
  - pat_in=16'h8421, pat_load at cycle 5 -> pat_pending=1 and rows stay 0000 until the boundary.
  - Next frame: rows 1000 @0111, 0100 @1011, 0010 @1101, 0001 @1110.
  - pat_pending clears at the boundary.
- Last-wins: pat_load 16'h000F then 16'hF000 in the same frame -> next frame shows rows 1000 on all four columns.
- Boundary-coincident load: pat_load 16'hFFFF on the boundary edge -> the frame starting there shows rows 1111 in active cycles; pat_pending never asserts.
- Blink:
  - 16'hFFFF displayed, blink_en=1 -> frames 0-1 show rows 1111 in active cycles.
  - Frames 2-3 show rows 0000 while led_col still scans 0111/1011/1101/1110.
  - Frames 4-5 show 1111 again.
  - With blink_en=0: 1111 in every frame.
- Mid-operation reset:
  - 16'hFFFF displayed, rst=0 for 1 cycle mid-column -> next cycle led_col=1111, led_row=0000.
  - After release the scan restarts with column 3 and rows 0000 (disp cleared).
